// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-port arbiter and access sequencer for a single-port RAM.
// Latency: gnt/ram_cs one cycle after req is sampled in IDLE, ack ACC_CYC cycles after grant.
// Backpressure: req is held until ack; every access is followed by one bus-idle TURN cycle.
// Ports: req/we/addr/wdata in and gnt/ack/rdata out per requester (0 = CPU, 1 = loader);
//        ram_cs/ram_we/ram_addr/ram_wdata/ram_wdata_oe drive the RAM, ram_rdata returns data;
//        busy is high whenever the sequencer is not IDLE.
// Optional: define ARB_LOCK_EN to add lock0/lock1 so a port can keep the RAM back-to-back.
module ram_port_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 4,
    parameter int ACC_CYC = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
`ifdef ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wdata_oe,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, TURN = 2'd2} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          last, last_nxt;      // port that most recently released the RAM
    logic          owner, owner_nxt;    // port of the access in flight
    logic          lat_we, lat_we_nxt;
    logic [AW-1:0] lat_addr, lat_addr_nxt;
    logic [DW-1:0] lat_wdata, lat_wdata_nxt;
    logic          ack0_nxt, ack1_nxt;
    logic [DW-1:0] rdata0_nxt, rdata1_nxt;
    logic          pick;
    logic          relock;

`ifdef ARB_LOCK_EN
    assign relock = owner ? (lock1 & req1) : (lock0 & req0);
`else
    assign relock = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_nxt      = last;
        owner_nxt     = owner;
        lat_we_nxt    = lat_we;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        ack0_nxt      = 1'b0;
        ack1_nxt      = 1'b0;
        rdata0_nxt    = rdata0;
        rdata1_nxt    = rdata1;

        // A tie in IDLE goes to the port that did not finish last; a locked
        // re-latch keeps the current owner.
        pick = owner;
        if (state == IDLE) begin
            pick = (req0 & req1) ? ~last : req1;
        end

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    owner_nxt     = pick;
                    lat_we_nxt    = pick ? we1 : we0;
                    lat_addr_nxt  = pick ? addr1 : addr0;
                    lat_wdata_nxt = pick ? wdata1 : wdata0;
                    cnt_nxt       = CNT_LOAD;
                    state_nxt     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    if (!lat_we) begin
                        if (owner) rdata1_nxt = ram_rdata;
                        else       rdata0_nxt = ram_rdata;
                    end
                    ack0_nxt = ~owner;
                    ack1_nxt = owner;
                    if (relock) begin
                        // Locked port keeps the bus: no TURN, inputs re-sampled now.
                        lat_we_nxt    = pick ? we1 : we0;
                        lat_addr_nxt  = pick ? addr1 : addr0;
                        lat_wdata_nxt = pick ? wdata1 : wdata0;
                        cnt_nxt       = CNT_LOAD;
                    end else begin
                        last_nxt  = owner;
                        state_nxt = TURN;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last      <= 1'b1;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            owner     <= owner_nxt;
            lat_we    <= lat_we_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            rdata0    <= rdata0_nxt;
            rdata1    <= rdata1_nxt;
        end
    end

    assign ram_cs       = (state == ACCESS);
    assign ram_we       = ram_cs & lat_we;
    assign ram_addr     = lat_addr;
    assign ram_wdata    = lat_wdata;
    assign ram_wdata_oe = ram_cs & lat_we;
    assign gnt0         = ram_cs & ~owner;
    assign gnt1         = ram_cs & owner;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: two arbiter instances (ACC_CYC=1 as u0, ACC_CYC=3 as u1), each with
// its own RAM, driven by directed scenarios then random traffic, and compared every cycle
// against a timestamp-based reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 4;
    localparam int N  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n [N];
    logic          req0 [N], we0 [N], req1 [N], we1 [N], lock0 [N], lock1 [N];
    logic [AW-1:0] addr0 [N], addr1 [N], ram_addr [N];
    logic [DW-1:0] wdata0 [N], wdata1 [N], rdata0 [N], rdata1 [N];
    logic [DW-1:0] ram_wdata [N], ram_rdata [N];
    logic          gnt0 [N], ack0 [N], gnt1 [N], ack1 [N];
    logic          ram_cs [N], ram_we [N], ram_oe [N], busy [N];

    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;
    int  cyc = 0;

    ram_port_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(1)) u0 (
        .clk(clk), .reset(rst_n[0]),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .gnt0(gnt0[0]), .ack0(ack0[0]), .rdata0(rdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .gnt1(gnt1[0]), .ack1(ack1[0]), .rdata1(rdata1[0]),
`ifdef ARB_LOCK_EN
        .lock0(lock0[0]), .lock1(lock1[0]),
`endif
        .ram_cs(ram_cs[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_wdata_oe(ram_oe[0]), .ram_rdata(ram_rdata[0]),
        .busy(busy[0])
    );

    ram_port_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(3)) u1 (
        .clk(clk), .reset(rst_n[1]),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .gnt0(gnt0[1]), .ack0(ack0[1]), .rdata0(rdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .gnt1(gnt1[1]), .ack1(ack1[1]), .rdata1(rdata1[1]),
`ifdef ARB_LOCK_EN
        .lock0(lock0[1]), .lock1(lock1[1]),
`endif
        .ram_cs(ram_cs[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_wdata_oe(ram_oe[1]), .ram_rdata(ram_rdata[1]),
        .busy(busy[1])
    );

    // Unwritten RAM locations read as a fixed address pattern (0x005 reads 4'hA).
    function automatic logic [DW-1:0] init_pat(logic [AW-1:0] a);
        return a[3:0] ^ 4'hF;
    endfunction

    function automatic int acc_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Environment RAMs, written by the DUTs.
    logic [DW-1:0] ram [N][4096];
    bit            ram_v [N][4096];
    always @(posedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (ram_cs[d] === 1'b1 && ram_we[d] === 1'b1) begin
                ram[d][ram_addr[d]]   <= ram_wdata[d];
                ram_v[d][ram_addr[d]] <= 1'b1;
            end
        end
    end
    assign ram_rdata[0] = ram_v[0][ram_addr[0]] ? ram[0][ram_addr[0]] : init_pat(ram_addr[0]);
    assign ram_rdata[1] = ram_v[1][ram_addr[1]] ? ram[1][ram_addr[1]] : init_pat(ram_addr[1]);

    // Reference model: who owns the RAM, at which edge that access completes, and the
    // first edge at which a new grant may happen; plus its own copy of memory contents.
    int            m_own  [N] = '{default: -1};
    int            m_done [N] = '{default: 0};
    int            m_free [N] = '{default: 0};
    int            m_ack  [N] = '{default: -1};
    bit            m_last [N] = '{default: 1'b1};
    bit            m_we   [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_wd   [N];
    logic [DW-1:0] m_rd   [N][2];
    logic [DW-1:0] mm     [N][4096];
    bit            mv     [N][4096];

    task automatic mload(int d, int p);
        m_we[d]   = (p == 1) ? we1[d] : we0[d];
        m_addr[d] = (p == 1) ? addr1[d] : addr0[d];
        m_wd[d]   = (p == 1) ? wdata1[d] : wdata0[d];
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < N; d++) begin
            bit lk;
            int p;
            m_ack[d] = -1;
            // Any edge seen while a write owns the bus stores into the RAM.
            if (m_own[d] >= 0 && m_we[d]) begin
                mm[d][m_addr[d]] = m_wd[d];
                mv[d][m_addr[d]] = 1'b1;
            end
            if (rst_n[d] !== 1'b1) begin
                m_own[d] = -1; m_last[d] = 1'b1; m_free[d] = 0;
                m_rd[d][0] = '0; m_rd[d][1] = '0;
            end else if (m_own[d] >= 0) begin
                if (cyc == m_done[d]) begin
                    if (!m_we[d])
                        m_rd[d][m_own[d]] = mv[d][m_addr[d]] ? mm[d][m_addr[d]] : init_pat(m_addr[d]);
                    m_ack[d] = m_own[d];
                    lk = (m_own[d] == 0) ? (lock0[d] && req0[d]) : (lock1[d] && req1[d]);
                    if (lk) begin
                        mload(d, m_own[d]);
                        m_done[d] = cyc + acc_of(d);
                    end else begin
                        m_last[d] = (m_own[d] == 1);
                        m_own[d]  = -1;
                        m_free[d] = cyc + 2;
                    end
                end
            end else if (cyc >= m_free[d] && (req0[d] || req1[d])) begin
                if (req0[d] && req1[d]) p = m_last[d] ? 0 : 1;
                else                    p = req1[d] ? 1 : 0;
                m_own[d]  = p;
                mload(d, p);
                m_done[d] = cyc + acc_of(d);
            end
        end
        cyc++;
    end

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s u%0d: got %0h expected %0h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < N; d++) begin
                bit cs;
                cs = (m_own[d] >= 0);
                chk("gnt0", d, gnt0[d], m_own[d] == 0);
                chk("gnt1", d, gnt1[d], m_own[d] == 1);
                chk("ack0", d, ack0[d], m_ack[d] == 0);
                chk("ack1", d, ack1[d], m_ack[d] == 1);
                chk("rdata0", d, rdata0[d], m_rd[d][0]);
                chk("rdata1", d, rdata1[d], m_rd[d][1]);
                chk("ram_cs", d, ram_cs[d], cs);
                chk("ram_we", d, ram_we[d], cs && m_we[d]);
                chk("ram_oe", d, ram_oe[d], cs && m_we[d]);
                chk("busy", d, busy[d], cs || (cyc < m_free[d]));
                if (cs) chk("ram_addr", d, ram_addr[d], m_addr[d]);
                if (cs && m_we[d]) chk("ram_wdata", d, ram_wdata[d], m_wd[d]);
            end
        end
    end

    task automatic set_req(int d, int p, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] x);
        if (p == 0) begin req0[d] = r; we0[d] = w; addr0[d] = a; wdata0[d] = x; end
        else        begin req1[d] = r; we1[d] = w; addr1[d] = a; wdata1[d] = x; end
    endtask

    // Wait for the next ack on instance d; counts negedges and ram_cs-high negedges.
    task automatic wait_ack(int d, int maxc, output bit got, output int who,
                            output int ncyc, output int ncs);
        got = 1'b0; who = -1; ncyc = 0; ncs = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            ncyc++;
            if (ram_cs[d] === 1'b1) ncs++;
            if (ack0[d] === 1'b1 || ack1[d] === 1'b1) begin
                got = 1'b1;
                who = (ack1[d] === 1'b1) ? 1 : 0;
                return;
            end
        end
    endtask

    initial begin
        bit got;
        int who, nc, ncs, gc;
        int exp_rr [4] = '{0, 1, 0, 1};
`ifdef ARB_LOCK_EN
        int exp_lk [4] = '{1, 1, 1, 0};
        int tw [4];
`endif
        for (int d = 0; d < N; d++) begin
            rst_n[d] = 1'b0; lock0[d] = 1'b0; lock1[d] = 1'b0;
            set_req(d, 0, 0, 0, '0, '0);
            set_req(d, 1, 0, 0, '0, '0);
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        for (int d = 0; d < N; d++) begin
            chk("rst_busy", d, busy[d], 0);
            chk("rst_gnt0", d, gnt0[d], 0);
            chk("rst_cs", d, ram_cs[d], 0);
            rst_n[d] = 1'b1;
        end

        // Read of preloaded 0x005 on the single-cycle instance.
        set_req(0, 0, 1, 0, 12'h005, 4'h0);
        wait_ack(0, 10, got, who, nc, ncs);
        set_req(0, 0, 0, 0, 12'h005, 4'h0);
        chk("t1_ack0", 0, got && who == 0, 1);
        chk("t1_latency", 0, nc, 2);
        chk("t1_cs_cycles", 0, ncs, 1);
        chk("t1_rdata0", 0, rdata0[0], 4'hA);

        // Three-cycle write to 0xFFF from port 1, then read it back.
        set_req(1, 1, 1, 1, 12'hFFF, 4'h7);
        wait_ack(1, 12, got, who, nc, ncs);
        chk("t3_ack1", 1, got && who == 1, 1);
        chk("t3_latency", 1, nc, 4);
        chk("t3_cs_cycles", 1, ncs, 3);
        set_req(1, 1, 1, 0, 12'hFFF, 4'h0);
        wait_ack(1, 12, got, who, nc, ncs);
        set_req(1, 1, 0, 0, 12'h0, 4'h0);
        chk("t3_rdata1", 1, rdata1[1], 4'h7);

        // Fresh reset, then both ports held: round-robin order from port 0.
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        set_req(0, 0, 1, 0, 12'h010, 4'h0);
        set_req(0, 1, 1, 0, 12'h020, 4'h0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, 10, got, who, nc, ncs);
            chk("t2_order", 0, who, exp_rr[k]);
        end
        set_req(0, 0, 0, 0, '0, '0);
        set_req(0, 1, 0, 0, '0, '0);

        // Request dropped right after grant still completes; a pulse in TURN is ignored.
        set_req(1, 0, 1, 1, 12'h0AB, 4'h3);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (gnt0[1] === 1'b1) got = 1'b1;
        end
        chk("t4_gnt0", 1, got, 1);
        @(negedge clk);
        req0[1] = 1'b0;
        wait_ack(1, 10, got, who, nc, ncs);
        chk("t4_ack0", 1, got && who == 0, 1);
        req0[1] = 1'b1;
        @(posedge clk);
        #1 req0[1] = 1'b0;
        gc = 0;
        repeat (6) begin
            @(negedge clk);
            if (gnt0[1] === 1'b1) gc++;
        end
        chk("t4_no_grant", 1, gc, 0);

        // Reset in the middle of a write aborts it; afterwards a tie goes to port 0.
        set_req(1, 0, 1, 1, 12'h123, 4'h5);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (gnt0[1] === 1'b1) got = 1'b1;
        end
        chk("t5_gnt0", 1, got, 1);
        @(negedge clk);
        rst_n[1] = 1'b0;
        set_req(1, 0, 0, 0, '0, '0);
        @(negedge clk);
        chk("t5_cs", 1, ram_cs[1], 0);
        chk("t5_busy", 1, busy[1], 0);
        chk("t5_ack0", 1, ack0[1], 0);
        rst_n[1] = 1'b1;
        set_req(1, 0, 1, 0, 12'h123, 4'h0);
        set_req(1, 1, 1, 0, 12'h124, 4'h0);
        @(negedge clk);
        chk("t5_tie_gnt0", 1, gnt0[1], 1);
        chk("t5_tie_gnt1", 1, gnt1[1], 0);
        wait_ack(1, 10, got, who, nc, ncs);
        set_req(1, 0, 0, 0, '0, '0);
        set_req(1, 1, 0, 0, '0, '0);
        repeat (3) @(negedge clk);

`ifdef ARB_LOCK_EN
        // Port 1 locked for three reads, then released; port 0 follows after TURN.
        lock1[0] = 1'b1;
        set_req(0, 1, 1, 0, 12'h030, 4'h0);
        @(negedge clk);
        set_req(0, 0, 1, 0, 12'h040, 4'h0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, 10, got, who, nc, ncs);
            tw[k] = cyc;
            chk("t6_order", 0, who, exp_lk[k]);
            if (k == 1) lock1[0] = 1'b0;
        end
        chk("t6_back_to_back", 0, tw[2] - tw[0], 2);
        chk("t6_turn_gap", 0, tw[3] - tw[2], 3);
        set_req(0, 0, 0, 0, '0, '0);
        set_req(0, 1, 0, 0, '0, '0);
        repeat (3) @(negedge clk);
`endif

        // Random traffic on both instances.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                rst_n[d] = ($urandom_range(0, 199) != 0);
                if ($urandom_range(0, 1) == 1) begin
                    we0[d] = 1'($urandom_range(0, 1));
                    addr0[d] = 12'($urandom_range(0, 15));
                    wdata0[d] = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 1) == 1) begin
                    we1[d] = 1'($urandom_range(0, 1));
                    addr1[d] = 12'($urandom_range(0, 15));
                    wdata1[d] = 4'($urandom_range(0, 15));
                end
                req0[d] = req0[d] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                req1[d] = req1[d] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
`ifdef ARB_LOCK_EN
                lock0[d] = ($urandom_range(0, 3) == 0);
                lock1[d] = ($urandom_range(0, 3) == 0);
`endif
            end
        end
        for (int d = 0; d < N; d++) begin
            rst_n[d] = 1'b1; lock0[d] = 1'b0; lock1[d] = 1'b0;
            req0[d] = 1'b0; req1[d] = 1'b0;
        end
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
